fpu_float_to_int: RTL and testbench

Pipelined IEEE-754 single-precision to 32-bit integer converter (RISC-V FCVT.W.S / FCVT.WU.S semantics). It sits in the FPU execute cluster beside the add and multiply datapaths. Where int-to-float normalizes with a leading-zero count, this block denormalizes: it right-aligns the mantissa, derives round and sticky bits, rounds and saturates. It is a two-stage pipeline with valid/ready handshakes on both sides and full backpressure.

---
 rtl/fpu_float_to_int_pkg.sv | 44 ++++
 rtl/fpu_float_to_int_if.sv | 24 ++
 rtl/fpu_round_int.sv | 63 ++++++
 rtl/fpu_float_to_int.sv | 127 ++++++++++++
 tb/tb_fpu_float_to_int.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_float_to_int_pkg.sv
// Shared FPU types, constants and bit helpers.
// Used by the float-to-int converter and by its rounding/saturation stage.
package fpu_float_to_int_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } fpu_round_mode_t;

  typedef enum logic [2:0] {
    FC_ZERO      = 3'd0,
    FC_SUBNORMAL = 3'd1,
    FC_NORMAL    = 3'd2,
    FC_INF       = 3'd3,
    FC_NAN       = 3'd4
  } fpu_class_t;

  localparam logic [31:0] FPU_INT32_MAX  = 32'h7FFF_FFFF;
  localparam logic [31:0] FPU_INT32_MIN  = 32'h8000_0000;
  localparam logic [31:0] FPU_UINT32_MAX = 32'hFFFF_FFFF;

  // Stage-1 payload: aligned integer magnitude plus everything rounding needs.
  typedef struct packed {
    logic [31:0]     mag;
    logic            round;
    logic            sticky;
    logic            sign;
    fpu_class_t      cls;
    logic            ovf;
    logic            is_signed;
    fpu_round_mode_t rm;
  } f2i_align_t;

  // OR of the n_bits least significant bits of value (n_bits = 0 gives 0).
  function automatic logic get_sticky_bit_32(input logic [31:0] value, input logic [5:0] n_bits);
    logic [63:0] mask;
    mask = (64'd1 << n_bits) - 64'd1;
    return |(value & mask[31:0]);
  endfunction

endpackage

// File: rtl/fpu_float_to_int_if.sv
// Operand/result handshake bundle of the float-to-int converter.
// master = producer/consumer side, slave = converter side.
interface fpu_float_to_int_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_float;
  logic        in_signed;
  logic [2:0]  in_rm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_invalid;
  logic        out_inexact;

  modport master (
    output in_valid, in_float, in_signed, in_rm, out_ready,
    input  in_ready, out_valid, out_result, out_invalid, out_inexact
  );

  modport slave (
    input  in_valid, in_float, in_signed, in_rm, out_ready,
    output in_ready, out_valid, out_result, out_invalid, out_inexact
  );
endinterface

// File: rtl/fpu_round_int.sv
// Combinational round/range-check/saturate for float-to-integer conversion.
// Written against a 32-bit target so the 64-bit conversion path can mirror it.
module fpu_round_int
  import fpu_float_to_int_pkg::*;
(
  input  logic [31:0]     i_mag,
  input  logic            i_round,
  input  logic            i_sticky,
  input  logic            i_sign,
  input  fpu_class_t      i_cls,
  input  logic            i_ovf,
  input  logic            i_is_signed,
  input  fpu_round_mode_t i_rm,
  output logic [31:0]     o_result,
  output logic            o_invalid,
  output logic            o_inexact
);

  logic        w_inc;
  logic [32:0] w_rounded;
  logic        w_in_range;

  // NOTE: every output of a combinational block gets a default before any
  // branch; a path that leaves one unassigned would infer a latch.
  always_comb begin
    w_inc = 1'b0;
    unique case (i_rm)
      RM_RNE:  w_inc = i_round & (i_sticky | i_mag[0]);
      RM_RDN:  w_inc = i_sign & (i_round | i_sticky);
      RM_RUP:  w_inc = ~i_sign & (i_round | i_sticky);
      RM_RMM:  w_inc = i_round;
      default: w_inc = 1'b0;
    endcase
  end

  // One extra bit so rounding up 0xFFFFFFFF is caught as out of range.
  assign w_rounded = {1'b0, i_mag} + {32'd0, w_inc};

  always_comb begin
    if (i_is_signed)
      w_in_range = i_sign ? (w_rounded <= 33'h0_8000_0000) : (w_rounded <= 33'h0_7FFF_FFFF);
    else
      w_in_range = i_sign ? (w_rounded == 33'd0) : ~w_rounded[32];
  end

  always_comb begin
    o_result  = 32'd0;
    o_invalid = 1'b0;
    o_inexact = 1'b0;
    if (i_cls == FC_NAN) begin
      o_result  = i_is_signed ? FPU_INT32_MAX : FPU_UINT32_MAX;
      o_invalid = 1'b1;
    end else if (i_cls == FC_INF || i_ovf || !w_in_range) begin
      if (i_is_signed) o_result = i_sign ? FPU_INT32_MIN : FPU_INT32_MAX;
      else             o_result = i_sign ? 32'd0 : FPU_UINT32_MAX;
      o_invalid = 1'b1;
    end else begin
      o_result  = i_sign ? -w_rounded[31:0] : w_rounded[31:0];
      o_inexact = i_round | i_sticky;
    end
  end

endmodule

// File: rtl/fpu_float_to_int.sv
// Two-stage IEEE-754 single to 32-bit integer converter (FCVT.W.S / FCVT.WU.S).
// Define FPU_FLOAT_TO_INT_DENORMAL_EN to convert subnormals exactly instead of flushing them.
module fpu_float_to_int
  import fpu_float_to_int_pkg::*;
(
  input logic              clk,
  input logic              rst,
  fpu_float_to_int_if.slave bus
);

  logic [7:0]        w_exp;
  logic [22:0]       w_frac;
  logic [31:0]       w_m;
  logic signed [9:0] w_e;
  logic [4:0]        w_e_lo;
  logic [4:0]        w_rsh;
  f2i_align_t        w_s1;

  assign w_exp  = bus.in_float[30:23];
  assign w_frac = bus.in_float[22:0];
  assign w_m    = {8'h00, 1'b1, w_frac};
  assign w_e    = signed'({2'b00, w_exp}) - 10'sd127;
  assign w_e_lo = w_e[4:0];
  assign w_rsh  = 5'd23 - w_e_lo;

  // Stage 1: classify and right-align the mantissa onto the integer grid.
  always_comb begin
    w_s1           = '0;
    w_s1.sign      = bus.in_float[31];
    w_s1.is_signed = bus.in_signed;
    w_s1.rm        = (bus.in_rm > 3'd4) ? RM_RTZ : fpu_round_mode_t'(bus.in_rm);
    w_s1.cls       = FC_NORMAL;
    if (w_exp == 8'hFF) begin
      w_s1.cls = (w_frac != 23'd0) ? FC_NAN : FC_INF;
    end else if (w_exp == 8'h00) begin
      if (w_frac == 23'd0) begin
        w_s1.cls = FC_ZERO;
      end else begin
`ifdef FPU_FLOAT_TO_INT_DENORMAL_EN
        w_s1.cls    = FC_SUBNORMAL;
        w_s1.sticky = 1'b1;
`else
        w_s1.cls = FC_ZERO;
`endif
      end
    end else if (w_e >= 10'sd32) begin
      w_s1.ovf = 1'b1;
    end else if (w_e >= 10'sd23) begin
      w_s1.mag = w_m << (w_e_lo - 5'd23);
    end else if (w_e >= 10'sd0) begin
      w_s1.mag    = w_m >> w_rsh;
      w_s1.round  = w_m[w_rsh - 5'd1];
      w_s1.sticky = get_sticky_bit_32(w_m, {1'b0, w_rsh - 5'd1});
    end else if (w_e == -10'sd1) begin
      w_s1.round  = 1'b1;
      w_s1.sticky = |w_frac;
    end else begin
      w_s1.sticky = 1'b1;
    end
  end

  logic        r_s1_valid;
  f2i_align_t  r_s1;
  logic        r_out_valid;
  logic [31:0] r_out_result;
  logic        r_out_invalid;
  logic        r_out_inexact;
  logic        w_s1_advance;
  logic        w_in_ready;
  logic [31:0] w_result;
  logic        w_invalid;
  logic        w_inexact;

  assign w_s1_advance = ~r_out_valid | bus.out_ready;
  assign w_in_ready   = ~rst & (~r_s1_valid | w_s1_advance);

  // NOTE: state is written with <= so every register samples pre-edge values;
  // blocking = here would let a later stage see this cycle's update.
  always_ff @(posedge clk) begin
    if (rst)             r_s1_valid <= 1'b0;
    else if (w_in_ready) r_s1_valid <= bus.in_valid;
  end

  // NOTE: payload registers carry no reset; they are only observed when the
  // matching valid bit is set, and that bit is reset.
  always_ff @(posedge clk) begin
    if (bus.in_valid && w_in_ready) r_s1 <= w_s1;
  end

  fpu_round_int u_round (
    .i_mag       (r_s1.mag),
    .i_round     (r_s1.round),
    .i_sticky    (r_s1.sticky),
    .i_sign      (r_s1.sign),
    .i_cls       (r_s1.cls),
    .i_ovf       (r_s1.ovf),
    .i_is_signed (r_s1.is_signed),
    .i_rm        (r_s1.rm),
    .o_result    (w_result),
    .o_invalid   (w_invalid),
    .o_inexact   (w_inexact)
  );

  // Stage 2: result registers are reset because they drive the ports directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_result  <= 32'd0;
      r_out_invalid <= 1'b0;
      r_out_inexact <= 1'b0;
    end else if (w_s1_advance) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_result  <= w_result;
        r_out_invalid <= w_invalid;
        r_out_inexact <= w_inexact;
      end
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_result  = r_out_result;
  assign bus.out_invalid = r_out_invalid;
  assign bus.out_inexact = r_out_inexact;

endmodule

// File: tb/tb_fpu_float_to_int.sv
// Self-checking bench for fpu_float_to_int: directed corner cases, randomized
// traffic against a real-arithmetic reference model, backpressure and reset.
module tb_fpu_float_to_int;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpu_float_to_int_if bus ();

  fpu_float_to_int dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] f;
    logic        sgn;
    logic [2:0]  rm;
    logic [33:0] want;   // {result, nv, nx}
    int          id;
  } op_t;

  op_t         pend[$];
  op_t         exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          n_acc = 0;
  int          n_out = 0;
  int          next_id = 0;
  logic        prev_stall = 1'b0;
  logic [34:0] prev_out = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  // Reference: exact real value of the operand, rounded with floor/ceil.
  function automatic logic [33:0] model(input logic [31:0] f, input logic sgn, input logic [2:0] rm);
    logic [7:0]  ex;
    logic [22:0] fr;
    logic        neg;
    logic [31:0] sat;
    real         a, x, fl, rr, d;
    longint      r, lo, hi;
    int          k;
    ex  = f[30:23];
    fr  = f[22:0];
    neg = f[31];
    sat = sgn ? (neg ? 32'h8000_0000 : 32'h7FFF_FFFF) : (neg ? 32'h0 : 32'hFFFF_FFFF);
    if (ex == 8'hFF)
      return (fr != 23'd0) ? {(sgn ? 32'h7FFF_FFFF : 32'hFFFF_FFFF), 2'b10} : {sat, 2'b10};
    if (ex >= 8'd161) return {sat, 2'b10};
`ifndef FPU_FLOAT_TO_INT_DENORMAL_EN
    if (ex == 8'd0) return 34'd0;
`endif
    if (ex == 8'd0) begin
      a = $itor({9'd0, fr});
      k = -149;
    end else begin
      a = $itor({8'd0, 1'b1, fr});
      k = int'(ex) - 150;
    end
    while (k > 0) begin a = a * 2.0; k--; end
    while (k < 0) begin a = a * 0.5; k++; end
    x  = neg ? -a : a;
    fl = $floor(x);
    case (rm)
      3'd0: begin
        d = x - fl;
        if (d > 0.5)      rr = fl + 1.0;
        else if (d < 0.5) rr = fl;
        else              rr = (longint'(fl) % 2 == 0) ? fl : fl + 1.0;
      end
      3'd2:    rr = fl;
      3'd3:    rr = $ceil(x);
      3'd4:    rr = (x >= 0.0) ? $floor(x + 0.5) : -$floor(-x + 0.5);
      default: rr = (x >= 0.0) ? fl : $ceil(x);
    endcase
    r  = longint'(rr);
    lo = sgn ? -64'sd2147483648 : 64'sd0;
    hi = sgn ? 64'sd2147483647 : 64'sd4294967295;
    if (r < lo || r > hi) return {sat, 2'b10};
    return {r[31:0], 1'b0, (rr != x)};
  endfunction

  task automatic push_op(input logic [31:0] f, input logic sgn, input logic [2:0] rm, input logic [33:0] want);
    op_t op;
    op.f    = f;
    op.sgn  = sgn;
    op.rm   = rm;
    op.want = want;
    op.id   = next_id++;
    pend.push_back(op);
  endtask

  // One clock: drive at the falling edge, sample 1 ns later, score the
  // transfers that the following rising edge will perform.
  task automatic step(input logic ordy, input logic ven);
    op_t e;
    @(negedge clk);
    bus.out_ready = ordy;
    if (pend.size() > 0 && ven) begin
      bus.in_valid  = 1'b1;
      bus.in_float  = pend[0].f;
      bus.in_signed = pend[0].sgn;
      bus.in_rm     = pend[0].rm;
    end else begin
      bus.in_valid = 1'b0;
    end
    #1;
    if (prev_stall)
      check("hold", 64'({bus.out_valid, bus.out_result, bus.out_invalid, bus.out_inexact}), 64'(prev_out));
    if (bus.in_valid && bus.in_ready) begin
      exp_q.push_back(pend[0]);
      void'(pend.pop_front());
      n_acc++;
    end
    if (bus.out_valid && bus.out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check("spurious_out", 64'(bus.out_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("res#%0d f=%h s=%0d rm=%0d", e.id, e.f, e.sgn, e.rm),
              64'({bus.out_result, bus.out_invalid, bus.out_inexact}), 64'(e.want));
      end
    end
    prev_stall = bus.out_valid & ~bus.out_ready;
    prev_out   = {bus.out_valid, bus.out_result, bus.out_invalid, bus.out_inexact};
  endtask

  task automatic drain(input int target, input int budget, input logic rnd);
    int guard;
    guard = 0;
    while (n_out < target && guard < budget) begin
      if (rnd) step(($urandom % 4) != 0, ($urandom % 4) != 0);
      else     step(1'b1, 1'b1);
      guard++;
    end
    check("drain_count", 64'(n_out), 64'(target));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base;
    logic [7:0]  ex;
    logic [31:0] rv, f;
    logic        sg;
    logic [2:0]  rm;
    bus.in_valid  = 1'b0;
    bus.in_float  = 32'd0;
    bus.in_signed = 1'b0;
    bus.in_rm     = 3'd0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out", 64'({bus.out_valid, bus.out_result, bus.out_invalid, bus.out_inexact}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Directed corner cases, back to back with mode changes
    push_op(32'h4020_0000, 1'b1, 3'd0, {32'd2, 2'b01});
    push_op(32'h4020_0000, 1'b1, 3'd4, {32'd3, 2'b01});
    push_op(32'h4020_0000, 1'b1, 3'd3, {32'd3, 2'b01});
    push_op(32'h4020_0000, 1'b1, 3'd1, {32'd2, 2'b01});
    push_op(32'hC020_0000, 1'b0, 3'd1, {32'd0, 2'b10});
    push_op(32'hBF00_0000, 1'b0, 3'd1, {32'd0, 2'b01});
    push_op(32'h4F00_0000, 1'b1, 3'd1, {32'h7FFF_FFFF, 2'b10});
    push_op(32'h4F00_0000, 1'b0, 3'd1, {32'h8000_0000, 2'b00});
    push_op(32'hCF00_0000, 1'b1, 3'd1, {32'h8000_0000, 2'b00});
    push_op(32'h7FC0_0000, 1'b1, 3'd0, {32'h7FFF_FFFF, 2'b10});
    push_op(32'hFF80_0000, 1'b0, 3'd0, {32'd0, 2'b10});
`ifdef FPU_FLOAT_TO_INT_DENORMAL_EN
    push_op(32'h0000_0001, 1'b1, 3'd3, {32'd1, 2'b01});
`else
    push_op(32'h0000_0001, 1'b1, 3'd3, {32'd0, 2'b00});
`endif
    push_op(32'h8000_0000, 1'b0, 3'd2, {32'd0, 2'b00});
    push_op(32'h4F80_0000, 1'b0, 3'd0, {32'hFFFF_FFFF, 2'b10});
    drain(n_out + 14, 200, 1'b0);

    // Randomized traffic with bubbles and random backpressure
    base = n_out;
    for (int i = 0; i < 300; i++) begin
      rv = $urandom;
      case ($urandom_range(0, 9))
        0:       ex = 8'hFF;
        1:       ex = 8'h00;
        2:       ex = 8'($urandom_range(120, 128));
        default: ex = 8'($urandom_range(140, 163));
      endcase
      f  = {rv[31], ex, rv[22:0]};
      sg = 1'($urandom);
      rm = 3'($urandom_range(0, 7));
      push_op(f, sg, rm, model(f, sg, rm));
    end
    drain(base + 300, 6000, 1'b1);

    // Backpressure: two operands fit, then in_ready drops and output holds
    base = n_out;
    for (int i = 0; i < 4; i++) begin
      f  = {1'($urandom), 8'($urandom_range(124, 150)), 23'($urandom)};
      sg = 1'($urandom);
      rm = 3'($urandom_range(0, 4));
      push_op(f, sg, rm, model(f, sg, rm));
    end
    n_acc = 0;
    repeat (5) step(1'b0, 1'b1);
    check("bp_accepted", 64'(n_acc), 64'd2);
    check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    check("bp_out_valid", 64'(bus.out_valid), 64'd1);
    drain(base + 4, 100, 1'b0);

    // Reset with two operands in flight: neither may emerge
    for (int i = 0; i < 2; i++) begin
      f = {1'b0, 8'($urandom_range(127, 140)), 23'($urandom)};
      push_op(f, 1'b1, 3'd0, model(f, 1'b1, 3'd0));
    end
    n_acc = 0;
    repeat (2) step(1'b0, 1'b1);
    check("rst_inflight_acc", 64'(n_acc), 64'd2);
    @(negedge clk);
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("rst_hold_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    check("rst_flush_out_valid", 64'(bus.out_valid), 64'd0);
    exp_q.delete();
    pend.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_release_in_ready", 64'(bus.in_ready), 64'd1);
    base = n_out;
    repeat (6) step(1'b1, 1'b1);
    check("rst_no_emit", 64'(n_out), 64'(base));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
